regfile_step_seq: RTL and testbench

Single-clock control sequencer that drives the register-file/ALU datapath's three stage strobes (operand read, ALU result capture, write-back) in order. It latches one operation from the board switches on a start press and replaces hand-clocked stage buttons. It sits between the switch/button inputs and the datapath. Its outputs are one-cycle enable pulses plus held address/opcode fields, so the datapath can run on the one system clock.

---
 rtl/regfile_step_seq.sv | 153 +++++++++++++++
 tb/tb_regfile_step_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_step_seq.sv
// Stage sequencer: latches one switch-defined operation on a start press and issues rr/f/wb strobes.
// Latency: start edge to latch 2 cycles, GAP cycles per phase (or one step press each); no backpressure, busy marks a run.
module regfile_step_seq #(
    parameter int GAP = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step,
    input  logic       step_mode,
    input  logic       wr_en_in,
    input  logic [3:0] alu_op_in,
    input  logic [4:0] r_addr_a_in,
    input  logic [4:0] r_addr_b_in,
    input  logic [4:0] w_addr_in,
    output logic [3:0] ALU_OP,
    output logic [4:0] R_Addr_A,
    output logic [4:0] R_Addr_B,
    output logic [4:0] W_Addr,
    output logic       rr_pulse,
    output logic       f_pulse,
    output logic       wb_pulse,
    output logic       Reg_Write,
    output logic       busy,
    output logic       done,
    output logic [1:0] phase
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RR   = 3'd1,
        S_F    = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] start_sync, step_sync;
    logic       start_edge, step_edge;
    logic       start_rise, step_rise;
    logic       wr_en_q;
    logic       take, fire;
    logic       rr_n, f_n, wb_n, rw_n, done_n;

    // Reset to all ones so a button already held at reset release is not seen as a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_sync <= 2'b11;
            step_sync  <= 2'b11;
            start_edge <= 1'b1;
            step_edge  <= 1'b1;
        end else begin
            start_sync <= {start_sync[0], start};
            step_sync  <= {step_sync[0], step};
            start_edge <= start_sync[1];
            step_edge  <= step_sync[1];
        end
    end

    assign start_rise = start_sync[1] & ~start_edge;
    assign step_rise  = step_sync[1] & ~step_edge;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        take    = 1'b0;
        fire    = 1'b0;
        rr_n    = 1'b0;
        f_n     = 1'b0;
        wb_n    = 1'b0;
        rw_n    = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    take    = 1'b1;
                    state_n = S_RR;
                    cnt_n   = '0;
                end
            end
            S_RR, S_F, S_WB: begin
                // cnt freezes in step mode so a return to auto resumes mid-phase.
                fire = step_mode ? step_rise : (cnt == GAP_LAST);
                if (fire) begin
                    cnt_n = '0;
                    case (state)
                        S_RR: begin
                            rr_n    = 1'b1;
                            state_n = S_F;
                        end
                        S_F: begin
                            f_n     = 1'b1;
                            state_n = S_WB;
                        end
                        default: begin
                            wb_n    = 1'b1;
                            rw_n    = wr_en_q;
                            state_n = S_DONE;
                        end
                    endcase
                end else if (!step_mode) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_DONE: begin
                if (done) state_n = S_IDLE;
                else      done_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_en_q   <= 1'b0;
            ALU_OP    <= '0;
            R_Addr_A  <= '0;
            R_Addr_B  <= '0;
            W_Addr    <= '0;
            rr_pulse  <= 1'b0;
            f_pulse   <= 1'b0;
            wb_pulse  <= 1'b0;
            Reg_Write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rr_pulse  <= rr_n;
            f_pulse   <= f_n;
            wb_pulse  <= wb_n;
            Reg_Write <= rw_n;
            done      <= done_n;
            busy      <= (state_n != S_IDLE);
            if (take) begin
                wr_en_q  <= wr_en_in;
                ALU_OP   <= alu_op_in;
                R_Addr_A <= r_addr_a_in;
                R_Addr_B <= r_addr_b_in;
                W_Addr   <= w_addr_in;
            end
        end
    end

    // DONE shares phase 0 with IDLE.
    assign phase = state[1:0];

endmodule

// File: tb/tb_regfile_step_seq.sv
// Directed bench for regfile_step_seq with GAP=3: auto timing table, step mode, restart, reset, mode switch.
module tb_regfile_step_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic       step_mode = 1'b0;
    logic       wr_en_in = 1'b0;
    logic [3:0] alu_op_in = '0;
    logic [4:0] r_addr_a_in = '0;
    logic [4:0] r_addr_b_in = '0;
    logic [4:0] w_addr_in = '0;
    logic [3:0] ALU_OP;
    logic [4:0] R_Addr_A, R_Addr_B, W_Addr;
    logic       rr_pulse, f_pulse, wb_pulse, Reg_Write, busy, done;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    regfile_step_seq #(.GAP(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .step_mode(step_mode),
        .wr_en_in(wr_en_in), .alu_op_in(alu_op_in), .r_addr_a_in(r_addr_a_in),
        .r_addr_b_in(r_addr_b_in), .w_addr_in(w_addr_in),
        .ALU_OP(ALU_OP), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
        .rr_pulse(rr_pulse), .f_pulse(f_pulse), .wb_pulse(wb_pulse), .Reg_Write(Reg_Write),
        .busy(busy), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    // Observation vector: {rr, f, wb, Reg_Write, done, busy, phase[1:0]}
    typedef struct {
        int         k;
        logic [7:0] exp;
    } vec_t;

    vec_t        tab [11];
    logic [7:0]  trace  [0:31];
    logic [18:0] ftrace [0:31];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] obs();
        return {rr_pulse, f_pulse, wb_pulse, Reg_Write, done, busy, phase};
    endfunction

    function automatic logic [18:0] flds();
        return {ALU_OP, R_Addr_A, R_Addr_B, W_Addr};
    endfunction

    task automatic set_fields(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] w, input logic we);
        alu_op_in = op; r_addr_a_in = a; r_addr_b_in = b; w_addr_in = w; wr_en_in = we;
    endtask

    // start is first sampled high at edge k=1; released after k=4.
    task automatic run_trace(input int n);
        start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            tick();
            trace[k]  = obs();
            ftrace[k] = flds();
            if (k == 4) start = 1'b0;
        end
    endtask

    task automatic check_table(input string tag, input logic [7:0] mask);
        for (int i = 0; i < 11; i++)
            chk($sformatf("%s k=%0d", tag, tab[i].k), 32'(trace[tab[i].k]), 32'(tab[i].exp & mask));
    endtask

    task automatic step_press(input string tag, input logic [3:0] exp_p, input logic exp_done);
        int early;
        early = 0;
        step = 1'b1;
        tick();
        if (obs() >> 4 != 8'd0) early++;
        tick();
        if (obs() >> 4 != 8'd0) early++;
        tick();
        chk({tag, " early"}, 32'(early), 32'd0);
        chk({tag, " pulse"}, 32'(obs() >> 4), 32'(exp_p));
        step = 1'b0;
        tick();
        chk({tag, " after"}, {28'd0, obs() >> 4}, 32'd0);
        chk({tag, " done"}, 32'(done), 32'(exp_done));
        repeat (3) tick();
    endtask

    initial begin
        int n_rr, n_f, n_wb, n_rw, n_done, bad;
        tab[0]  = '{1,  8'b0000_0000};
        tab[1]  = '{2,  8'b0000_0000};
        tab[2]  = '{3,  8'b0000_0101};
        tab[3]  = '{5,  8'b0000_0101};
        tab[4]  = '{6,  8'b1000_0110};
        tab[5]  = '{7,  8'b0000_0110};
        tab[6]  = '{9,  8'b0100_0111};
        tab[7]  = '{11, 8'b0000_0111};
        tab[8]  = '{12, 8'b0011_0100};
        tab[9]  = '{13, 8'b0000_1100};
        tab[10] = '{14, 8'b0000_0000};

        repeat (3) tick();
        chk("reset outputs", 32'(obs()), 32'd0);
        chk("reset fields", 32'(flds()), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Auto run with write-back
        set_fields(4'h2, 5'd1, 5'd2, 5'd3, 1'b1);
        run_trace(16);
        check_table("auto_we1", 8'hFF);
        chk("auto_we1 fields pre-latch", 32'(ftrace[2]), 32'd0);
        chk("auto_we1 fields latched", 32'(ftrace[3]), 32'({4'h2, 5'd1, 5'd2, 5'd3}));
        chk("auto_we1 fields held", 32'(ftrace[16]), 32'({4'h2, 5'd1, 5'd2, 5'd3}));
        repeat (3) tick();

        // Auto run without write-back
        set_fields(4'h5, 5'd4, 5'd5, 5'd6, 1'b0);
        run_trace(16);
        check_table("auto_we0", 8'b1110_1111);
        n_rw = 0;
        for (int k = 1; k <= 16; k++) n_rw += int'(trace[k][4]);
        chk("auto_we0 reg_write count", 32'(n_rw), 32'd0);
        chk("auto_we0 fields latched", 32'(ftrace[3]), 32'({4'h5, 5'd4, 5'd5, 5'd6}));
        repeat (3) tick();

        // Step mode
        step_mode = 1'b1;
        set_fields(4'h7, 5'd8, 5'd9, 5'd10, 1'b1);
        start = 1'b1;
        bad = 0;
        for (int k = 1; k <= 52; k++) begin
            tick();
            if (k == 4) start = 1'b0;
            if (k >= 3 && (obs() >> 4 != 8'd0 || phase != 2'd1 || !busy)) bad++;
        end
        chk("step idle 50 cycles", 32'(bad), 32'd0);
        step_press("step rr", 4'b1000, 1'b0);
        step_press("step f", 4'b0100, 1'b0);
        step_press("step wb", 4'b0011, 1'b1);
        chk("step busy after done", 32'(busy), 32'd0);
        bad = 0;
        step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (obs() != 8'd0) bad++;
        end
        step = 1'b0;
        chk("step 4th press", 32'(bad), 32'd0);
        step_mode = 1'b0;
        repeat (3) tick();

        // Restart mid-run with changed switches
        set_fields(4'h2, 5'd1, 5'd2, 5'd3, 1'b1);
        start = 1'b1;
        n_rr = 0; n_f = 0; n_wb = 0; n_done = 0; bad = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 4) start = 1'b0;
            if (k == 7) begin
                set_fields(4'hF, 5'd31, 5'd30, 5'd29, 1'b0);
                start = 1'b1;
            end
            if (k == 9) start = 1'b0;
            n_rr += int'(rr_pulse); n_f += int'(f_pulse); n_wb += int'(wb_pulse);
            n_done += int'(done);
            if (k >= 3 && flds() != {4'h2, 5'd1, 5'd2, 5'd3}) bad++;
            if (k == 12) chk("restart reg_write", 32'(Reg_Write), 32'd1);
        end
        chk("restart pulse counts", 32'({n_rr[7:0], n_f[7:0], n_wb[7:0], n_done[7:0]}), 32'h01010101);
        chk("restart fields stable", 32'(bad), 32'd0);
        chk("restart idle at end", 32'(busy), 32'd0);
        repeat (3) tick();

        // Reset in the cycle after f_pulse, start held through reset release
        set_fields(4'h9, 5'd11, 5'd12, 5'd13, 1'b1);
        run_trace(10);
        chk("rst f_pulse seen", 32'(trace[9][6]), 32'd1);
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        chk("rst outputs cleared", 32'(obs()), 32'd0);
        chk("rst fields cleared", 32'(flds()), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (obs() != 8'd0) bad++;
        end
        chk("rst held start no run", 32'(bad), 32'd0);
        start = 1'b0;
        repeat (4) tick();
        run_trace(16);
        check_table("after_rst", 8'hFF);
        chk("after_rst fields", 32'(ftrace[3]), 32'({4'h9, 5'd11, 5'd12, 5'd13}));
        repeat (3) tick();

        // Auto -> step in F at cnt=1, ten cycles, back to auto
        set_fields(4'h3, 5'd7, 5'd6, 5'd5, 1'b1);
        run_trace(7);
        chk("mode rr at k6", 32'(trace[6]), 32'(8'b1000_0110));
        step_mode = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (f_pulse || phase != 2'd2) bad++;
        end
        chk("mode hold no f", 32'(bad), 32'd0);
        step_mode = 1'b0;
        tick();
        chk("mode f not yet", 32'(f_pulse), 32'd0);
        tick();
        chk("mode f after resume", 32'(f_pulse), 32'd1);
        repeat (10) tick();
        chk("mode run finished", 32'(obs()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
